// File: rtl/prog_loader.sv
// Serial program loader: receives NUM_BYTES UART-style frames and presents
// each byte with its address to a program RAM held in program mode.
module prog_loader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int NUM_BYTES    = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       ser_in,
    output logic       prog,
    output logic [7:0] prog_in,
    output logic [3:0] prog_add,
    output logic       busy,
    output logic       done,
    output logic       frame_err
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST    = 5'(NUM_BYTES);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, START_BIT, DATA, STOP, HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [4:0]    idx_q, idx_d;
    logic          prog_q, prog_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    add_q, add_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        prog_d  = prog_q;
        data_d  = data_q;
        add_d   = add_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_START;
                    busy_d  = 1'b1;
                    prog_d  = 1'b1;
                    idx_d   = '0;
                    add_d   = '0;
                    err_d   = 1'b0;
                end
            end
            WAIT_START: begin
                // The session-complete check sits here so the final byte gets a
                // full extra write cycle before HOLD.
                if (idx_q == LAST) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end else if (!ser_in) begin
                    state_d = START_BIT;
                    cnt_d   = '0;
                end
            end
            START_BIT: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ser_in ? WAIT_START : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {ser_in, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = WAIT_START;
                    if (ser_in) begin
                        data_d = shift_q;
                        add_d  = idx_q[3:0];
                        idx_d  = idx_q + 5'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                prog_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            prog_q  <= 1'b0;
            data_q  <= '0;
            add_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            prog_q  <= prog_d;
            data_q  <= data_d;
            add_q   <= add_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign prog      = prog_q;
    assign prog_in   = data_q;
    assign prog_add  = add_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a 16-byte instance checked through a
// commit scoreboard, plus a 1-byte instance for the single-frame session.
module tb_prog_loader;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       ser_in = 1'b1;
    logic       prog, busy, done, frame_err;
    logic [7:0] prog_in;
    logic [3:0] prog_add;
    logic       prog1, busy1, done1, frame_err1;
    logic [7:0] prog_in1;
    logic [3:0] prog_add1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_e0 = 0;

    logic [11:0] sb[$];
    logic [4:0]  prev_idx = '0;
    int commit_cyc = -1;
    int done_cnt = 0, done_cyc = -1, prog_fall = -1;
    logic prev_prog = 1'b0;
    logic [7:0] prev_in1 = '0;
    int chg1_cyc = -1, done1_cnt = 0, done1_cyc = -1, prog1_fall = -1;
    logic prev_prog1 = 1'b0;

    prog_loader #(.CLKS_PER_BIT(C), .NUM_BYTES(16)) dut (
        .clk(clk), .clear(clear), .start(start), .ser_in(ser_in),
        .prog(prog), .prog_in(prog_in), .prog_add(prog_add),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    prog_loader #(.CLKS_PER_BIT(C), .NUM_BYTES(1)) dut1 (
        .clk(clk), .clear(clear), .start(start1), .ser_in(ser_in),
        .prog(prog1), .prog_in(prog_in1), .prog_add(prog_add1),
        .busy(busy1), .done(done1), .frame_err(frame_err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Commit detection via the byte index advancing; expected bytes come from the queue.
    always @(negedge clk) begin
        logic [11:0] e;
        if (dut.idx_q != prev_idx) begin
            if (dut.idx_q == prev_idx + 5'd1) begin
                commit_cyc = cyc;
                check("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("commit_add", prog_add, e[11:8]);
                    check("commit_data", prog_in, e[7:0]);
                end
            end
            prev_idx = dut.idx_q;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (prev_prog && !prog) prog_fall = cyc;
        prev_prog = prog;
        if (prog_in1 != prev_in1) chg1_cyc = cyc;
        prev_in1 = prog_in1;
        if (done1) begin done1_cnt++; done1_cyc = cyc; end
        if (prev_prog1 && !prog1) prog1_fall = cyc;
        prev_prog1 = prog1;
    end

    task automatic drive_bit(input logic v);
        ser_in = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        @(posedge clk); #1;
        last_e0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
        ser_in = 1'b1;
    endtask

    task automatic pulse_start;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check(tag, {prog, prog_in, prog_add, busy, done, frame_err,
                    dut.idx_q, dut.shift_q, prog1, prog_in1, prog_add1, busy1}, '0);
    endtask

    task automatic do_reset;
        @(posedge clk); #3;
        clear = 1'b0;
        #1;
        check_reset("reset_async");
        sb.delete();
        ser_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        clear = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_reset("post_release_idle");

        // Single frame timing
        pulse_start;
        check("start_busy_prog", {busy, prog}, 2'b11);
        sb.push_back({4'h0, 8'hA5});
        send_frame(8'hA5, 1'b1);
        check("a5_commit_cycle", commit_cyc, last_e0 + 39);
        check("a5_data", prog_in, 8'hA5);
        check("a5_index", dut.idx_q, 5'd1);
        do_reset;

        // Glitch, bad stop bit, then good frame
        pulse_start;
        @(posedge clk); #1; ser_in = 1'b0;
        repeat (2) @(posedge clk); #1; ser_in = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("glitch_no_commit", {dut.idx_q, prog_in, prog_add}, '0);
        check("glitch_no_err", frame_err, 1'b0);
        check("glitch_busy", busy, 1'b1);
        send_frame(8'h3C, 1'b0);
        repeat (8) @(posedge clk); #1;
        check("bad_stop_err", frame_err, 1'b1);
        check("bad_stop_discard", {dut.idx_q, prog_in, prog_add}, '0);
        sb.push_back({4'h0, 8'h3C});
        send_frame(8'h3C, 1'b1);
        check("retry_data", prog_in, 8'h3C);
        check("err_sticky", frame_err, 1'b1);
        check("retry_sb_empty", sb.size(), 0);
        do_reset;

        // Full 16-byte session with an ignored start mid-session
        done_cnt = 0;
        pulse_start;
        for (int b = 0; b < 16; b++) begin
            sb.push_back({4'(b), 8'(b)});
            send_frame(8'(b), 1'b1);
            if (b == 3) pulse_start;
        end
        repeat (4) @(posedge clk); #1;
        check("full_done_count", done_cnt, 1);
        check("full_done_cycle", done_cyc, last_e0 + 40);
        check("full_prog_fall", prog_fall, last_e0 + 41);
        check("full_idle_outputs", {busy, prog, done}, 3'b000);
        check("full_last_byte", {prog_add, prog_in}, 12'hF0F);
        check("full_sb_empty", sb.size(), 0);

        // Abort mid-byte with a reset
        pulse_start;
        for (int b = 0; b < 7; b++) begin
            sb.push_back({4'(b), 8'h50 + 8'(b)});
            send_frame(8'h50 + 8'(b), 1'b1);
            if (b == 2) pulse_start;
        end
        check("pre_abort_data", {prog_add, prog_in}, 12'h656);
        check("pre_abort_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        ser_in = 1'b1;
        repeat (2) @(posedge clk); #3;
        clear = 1'b0;
        #1;
        check_reset("abort_reset");
        sb.delete();
        repeat (3) @(posedge clk); #1;
        clear = 1'b1;
        send_frame(8'h77, 1'b1);
        repeat (4) @(posedge clk); #1;
        check("no_start_ignored", {busy, prog, prog_in, prog_add}, '0);

        // NUM_BYTES=1 instance
        done1_cnt = 0;
        @(posedge clk); #1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        send_frame(8'hFF, 1'b1);
        repeat (4) @(posedge clk); #1;
        check("nb1_data", {prog_add1, prog_in1}, 12'h0FF);
        check("nb1_commit_cycle", chg1_cyc, last_e0 + 39);
        check("nb1_done_cycle", done1_cyc, last_e0 + 40);
        check("nb1_done_count", done1_cnt, 1);
        check("nb1_prog_fall", prog1_fall, last_e0 + 41);
        check("nb1_idle", {busy1, prog1}, 2'b00);
        check("idle_ser_ignored", {busy, prog_in}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clocks per serial bit; SHALL be an even value of at least 2.
REQ-002 Parameter NUM_BYTES, default 16: bytes per load session; SHALL be in the range 1..16.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 clear  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 ser_in  input  1  serial data, synchronous to clk, idle high.
REQ-007 prog  output  1  program-mode select; drives the RAM prog input.
REQ-008 prog_in  output  8  byte to write; drives the RAM prog_in input.
REQ-009 prog_add  output  4  write address; drives the RAM prog_add input.
REQ-010 busy  output  1  high while a session is active.
REQ-011 done  output  1  one-cycle pulse when a session completes.
REQ-012 frame_err  output  1  sticky stop-bit error flag.

Function
REQ-013 Serial frame SHALL be: start bit 0, then 8 data bits LSB first, then stop bit 1.
REQ-014 The state machine SHALL have these states: IDLE, WAIT_START, START_BIT, DATA, STOP, HOLD.
REQ-015 In IDLE, start=1 SHALL move to WAIT_START next cycle, setting busy=1 and prog=1, and clearing the byte index, prog_add and frame_err.
REQ-016 In every state except IDLE, start SHALL be ignored.
REQ-017 In WAIT_START, ser_in=0 at cycle D SHALL move to START_BIT.
REQ-018 START_BIT SHALL re-sample ser_in at cycle D+H, where H=CLKS_PER_BIT/2: a 0 moves to DATA; a 1 is a glitch and returns to WAIT_START with no error.
REQ-019 DATA SHALL sample data bit i (i=0..7) at cycle D+H+(i+1)*CLKS_PER_BIT and shift it into an 8-bit shift register.
REQ-020 STOP SHALL sample ser_in at cycle D+H+9*CLKS_PER_BIT.
REQ-021 On a stop bit of 1, prog_in SHALL take the shift register value and prog_add SHALL take the byte index, both on the same edge and valid from cycle D+H+9*CLKS_PER_BIT+1; the byte index then increments.
REQ-022 On a stop bit of 0, frame_err SHALL set, the byte SHALL be discarded, prog_in, prog_add and the byte index SHALL be unchanged, and the FSM SHALL return to WAIT_START.
REQ-023 prog_in and prog_add SHALL change only on a commit, so the RAM, which writes every clock while prog=1, rewrites the same byte between commits.
REQ-024 After the commit that brings the byte index to NUM_BYTES, the FSM SHALL enter HOLD for exactly 1 cycle with prog=1, giving at least one RAM write edge with the final data.
REQ-025 HOLD SHALL assert done=1 for that cycle and then go to IDLE, with prog=0 and busy=0 from the next cycle.
REQ-026 The byte index SHALL be 5 bits wide; prog_add SHALL equal index[3:0], with no wrap during a session.
REQ-027 frame_err SHALL remain set until the next accepted start or reset.
REQ-028 ser_in activity in IDLE SHALL have no effect.

Reset
REQ-029 clear=0 SHALL immediately force state IDLE, with prog=0, prog_in=8'h00, prog_add=4'h0, busy=0, done=0, frame_err=0, the shift register at 0 and the byte index at 0.
REQ-030 Reset mid-session SHALL abort the session without completing any partial byte; after release, a new start is required.
REQ-031 Outputs SHALL first change on the first rising edge after clear returns high.

Verification
REQ-032 CLKS_PER_BIT=4, NUM_BYTES=16: start, then 16 frames with bytes 8'h00..8'h0F -> prog_add/prog_in step through 0/00..F/0F; one done pulse; prog falls 1 cycle after done; busy low afterwards.
REQ-033 Single frame 8'hA5 -> prog_in=8'hA5 exactly at cycle D+39; prog_add=0; byte index=1.
REQ-034 Frame 8'h3C with stop bit 0, then a valid 8'h3C frame -> frame_err=1 after the first frame; the second frame commits at prog_add=0; frame_err stays 1.
REQ-035 2-cycle low glitch on ser_in in WAIT_START -> no commit, frame_err=0, state back in WAIT_START.
REQ-036 clear pulsed low during bit 4 of byte 7 -> all outputs return to reset values immediately; start pulses while busy before the reset are ignored.
REQ-037 NUM_BYTES=1, frame 8'hFF -> prog_in=8'hFF at prog_add 0; HOLD and done follow at cycle D+40.
